// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_pkg
// Description : Shared types and helpers for the slide-switch debouncer.
// Revision    : 1.0  initial release
// ============================================================================
package sw_pkg;

  // Per-bit debounce state
  typedef enum logic [0:0] {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } deb_state_e;

  // Fewer than two flops does not give a metastability-safe synchronizer
  localparam int MIN_SYNC_STAGES = 2;

  // Width of a counter that must hold values 0..max_count without wrapping
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_if
// Description : One-deep change-event channel (valid/ready) from the switch
//               conditioner to the fabric consumer.
// Revision    : 1.0  initial release
// ============================================================================
interface sw_debounce_if #(
  parameter int WIDTH = 2
) ();

  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_data;
  logic [WIDTH-1:0] evt_mask;
  logic             evt_overrun;

  // Producer side: the debouncer
  modport master (
    output evt_valid,
    output evt_data,
    output evt_mask,
    output evt_overrun,
    input  evt_ready
  );

  // Consumer side: fabric logic
  modport slave (
    input  evt_valid,
    input  evt_data,
    input  evt_mask,
    input  evt_overrun,
    output evt_ready
  );

endinterface
`default_nettype wire

// File: rtl/sw_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_bit
// Description : Single switch bit: synchronizer, stability counter,
//               debounce FSM and registered rise/fall pulses.
// Revision    : 1.0  initial release
// ============================================================================
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  deb_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Next-state: shift the synchronizer and run the stability counter
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sw_raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (sync_out != clean_q) begin
          state_d = COUNTING;
          cnt_d   = CNT_ONE;
        end
      end
      COUNTING: begin
        if (sync_out == clean_q) begin
          // Input went back before it had been stable long enough
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          clean_d = ~clean_q;
          rise_d  = ~clean_q;
          fall_d  = clean_q;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset clears the whole pipeline including the synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sw_clean = clean_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : Slide-switch conditioner. Debounces WIDTH switch bits and
//               reports changes through a one-deep valid/ready event
//               register with mask merging and a sticky overrun flag.
// Revision    : 1.0  initial release
// ============================================================================
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  sw_debounce_if.master    evt
);

  // Out-of-range parameters are clamped to the smallest safe values
  localparam int SYNC_EFF = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
  localparam int DEB_EFF  = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
    sw_debounce_bit #(
      .SYNC_STAGES     (SYNC_EFF),
      .DEBOUNCE_CYCLES (DEB_EFF)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .sw_raw   (sw_raw[gi]),
      .sw_clean (sw_clean[gi]),
      .sw_rise  (sw_rise[gi]),
      .sw_fall  (sw_fall[gi])
    );
  end

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] chg;
  logic             accept;

  assign chg    = sw_rise | sw_fall;
  assign accept = valid_q & evt.evt_ready;

  // Event register: load a fresh event, merge into a pending one, or retire on accept
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    mask_d    = mask_q;
    overrun_d = overrun_q;
    if (chg != '0) begin
      data_d = sw_clean;
      if (!valid_q || accept) begin
        // Nothing left pending after this edge, so the new change stands alone
        valid_d   = 1'b1;
        mask_d    = chg;
        overrun_d = 1'b0;
      end else begin
        mask_d    = mask_q | chg;
        overrun_d = overrun_q | (|(mask_q & chg));
      end
    end else if (accept) begin
      valid_d   = 1'b0;
      mask_d    = '0;
      overrun_d = 1'b0;
    end
  end

  // Event registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
    end
  end

  assign evt.evt_valid   = valid_q;
  assign evt.evt_data    = data_q;
  assign evt.evt_mask    = mask_q;
  assign evt.evt_overrun = overrun_q;

endmodule
`default_nettype wire
